// File: rtl/monster_pkg.sv
// monster_pkg: shared constants and types for the monster collision slice.
// Monster indices match the bit order of monster_eaten {randomD,randomS,tracker}.
package monster_pkg;

    localparam int MON_TRACKER  = 0;
    localparam int MON_RANDOM_S = 1;
    localparam int MON_RANDOM_D = 2;
    localparam int NUM_MONSTERS = 3;

    typedef enum logic {
        ARMED = 1'b0,
        GRACE = 1'b1
    } collision_state_t;

    typedef logic [3:0] edge_code_t;

endpackage

// File: rtl/frame_event_latch.sv
// frame_event_latch: one-shot event per frame.
// A registered pulse fires when cond is true and the frame flag is clear.
// startOfFrame clears the flag in the same cycle it is evaluated, so an
// overlap on the first pixel of a frame counts for the new frame.
module frame_event_latch (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic cond,
    output logic fire,
    output logic pulse
);

    logic flag;
    logic flag_cur;

    assign flag_cur = flag & ~startOfFrame;
    assign fire     = cond & ~flag_cur;

    // Hold the per-frame flag and register the pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flag  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            flag  <= flag_cur | fire;
            pulse <= fire;
        end
    end

endmodule

// File: rtl/monster_collision.sv
// monster_collision: overlap detection between pacman, monsters and walls
// during the raster scan, with a grace period after pacman is caught.
// Optional tracker wall detection: define MONSTER_WALL_HIT_EN.
module monster_collision
    import monster_pkg::*;
#(
    parameter int GRACE_FRAMES = 120,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    shiftImage,
    input  logic                    drawingRequest_pacman,
    input  logic                    drawingRequest_walls,
    input  logic                    drawingRequest_tracker,
    input  logic                    drawingRequest_randomS,
    input  logic                    drawingRequest_randomD,
    input  edge_code_t              HitEdgeCode_tracker,
    output logic                    pacman_caught,
    output logic [NUM_MONSTERS-1:0] monster_eaten,
    output logic                    tracker_wall_hit,
    output edge_code_t              tracker_wall_edge,
    output logic                    in_grace
);

    collision_state_t         state;
    logic [FRAME_CNT_W-1:0]   grace_cnt;
    logic [NUM_MONSTERS-1:0]  mon_req;
    logic [NUM_MONSTERS-1:0]  monster_hit;
    logic [NUM_MONSTERS-1:0]  eaten_cond;
    logic [NUM_MONSTERS-1:0]  eaten_fire_unused;
    logic                     armed;
    logic                     caught_cond;
    logic                     caught_fire;

    assign mon_req[MON_TRACKER]  = drawingRequest_tracker;
    assign mon_req[MON_RANDOM_S] = drawingRequest_randomS;
    assign mon_req[MON_RANDOM_D] = drawingRequest_randomD;

    assign monster_hit = {NUM_MONSTERS{drawingRequest_pacman}} & mon_req;
    assign armed       = (state == ARMED);

    // Frightened mode selects eat vs. catch; grace suppresses both.
    assign caught_cond = armed & ~shiftImage & (|monster_hit);
    assign eaten_cond  = {NUM_MONSTERS{armed & shiftImage}} & monster_hit;

    frame_event_latch u_caught (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .cond         (caught_cond),
        .fire         (caught_fire),
        .pulse        (pacman_caught)
    );

    frame_event_latch u_eaten [NUM_MONSTERS-1:0] (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .cond         (eaten_cond),
        .fire         (eaten_fire_unused),
        .pulse        (monster_eaten)
    );

    // Grace FSM: enter on a catch, count frames down, re-arm on the last one.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= ARMED;
            grace_cnt <= '0;
        end else begin
            case (state)
                ARMED: begin
                    if (caught_fire) begin
                        state     <= GRACE;
                        grace_cnt <= FRAME_CNT_W'(GRACE_FRAMES);
                    end
                end
                GRACE: begin
                    if (startOfFrame) begin
                        if (grace_cnt == FRAME_CNT_W'(1)) begin
                            state     <= ARMED;
                            grace_cnt <= '0;
                        end else if (grace_cnt != '0) begin
                            grace_cnt <= grace_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ARMED;
                    grace_cnt <= '0;
                end
            endcase
        end
    end

    assign in_grace = (state == GRACE);

`ifdef MONSTER_WALL_HIT_EN
    logic wall_fire;

    frame_event_latch u_wall (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .cond         (drawingRequest_tracker & drawingRequest_walls),
        .fire         (wall_fire),
        .pulse        (tracker_wall_hit)
    );

    // Capture the tracker edge code alongside the wall pulse; hold until next hit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tracker_wall_edge <= '0;
        end else if (wall_fire) begin
            tracker_wall_edge <= HitEdgeCode_tracker;
        end
    end
`else
    logic wall_inputs_unused;

    assign wall_inputs_unused = ^{drawingRequest_walls, HitEdgeCode_tracker};
    assign tracker_wall_hit   = 1'b0;
    assign tracker_wall_edge  = '0;
`endif

endmodule

// File: tb/tb_monster_collision.sv
// tb_monster_collision: directed vector table, hand sequences for reset and
// grace corners, then randomized traffic against a frame-level model.
module tb_monster_collision;

    localparam int GRACE = 3;
`ifdef MONSTER_WALL_HIT_EN
    localparam bit WALL_EN = 1'b1;
`else
    localparam bit WALL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0, shift = 1'b0, pac = 1'b0, wall = 1'b0;
    logic       trk = 1'b0, rs = 1'b0, rd = 1'b0;
    logic [3:0] ecode = 4'h0;
    logic       caught, wall_hit, grace;
    logic [2:0] eaten;
    logic [3:0] wall_edge;

    int checks = 0;
    int errors = 0;

    monster_collision #(.GRACE_FRAMES(GRACE), .FRAME_CNT_W(8)) dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (sof),
        .shiftImage             (shift),
        .drawingRequest_pacman  (pac),
        .drawingRequest_walls   (wall),
        .drawingRequest_tracker (trk),
        .drawingRequest_randomS (rs),
        .drawingRequest_randomD (rd),
        .HitEdgeCode_tracker    (ecode),
        .pacman_caught          (caught),
        .monster_eaten          (eaten),
        .tracker_wall_hit       (wall_hit),
        .tracker_wall_edge      (wall_edge),
        .in_grace               (grace)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sof, shift, pac, wall, trk, rs, rd;
        logic [3:0] ec;
        logic       e_caught;
        logic [2:0] e_eaten;
        logic       e_wall;
        logic [3:0] e_edge;
        logic       e_grace;
    } vec_t;

    // Frame-level reference: which events already happened this frame,
    // and how many frame starts remain until pacman is vulnerable again.
    bit         fired_caught, fired_wall;
    bit [2:0]   fired_eaten;
    bit         m_grace;
    int         m_left;
    bit         m_caught, m_wall;
    bit [2:0]   m_eaten;
    bit [3:0]   m_edge;

    task automatic model_reset();
        fired_caught = 0; fired_wall = 0; fired_eaten = 0;
        m_grace = 0; m_left = 0;
        m_caught = 0; m_wall = 0; m_eaten = 0; m_edge = 0;
    endtask

    task automatic model_step();
        bit [2:0] hit;
        hit = {pac & rd, pac & rs, pac & trk};
        if (sof) begin
            fired_caught = 0; fired_eaten = 0; fired_wall = 0;
        end
        m_caught = 0; m_eaten = 0; m_wall = 0;
        if (!m_grace) begin
            if (!shift) begin
                if (hit != 0 && !fired_caught) begin
                    m_caught = 1; fired_caught = 1;
                    m_grace = 1; m_left = GRACE;
                end
            end else begin
                for (int i = 0; i < 3; i++)
                    if (hit[i] && !fired_eaten[i]) begin
                        m_eaten[i] = 1; fired_eaten[i] = 1;
                    end
            end
        end else if (sof) begin
            m_left = m_left - 1;
            if (m_left <= 0) begin
                m_grace = 0; m_left = 0;
            end
        end
        if (WALL_EN && trk && wall && !fired_wall) begin
            m_wall = 1; fired_wall = 1; m_edge = ecode;
        end
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got caught=%b eaten=%b wall=%b edge=%h grace=%b, want caught=%b eaten=%b wall=%b edge=%h grace=%b",
                     name, act[10], act[9:7], act[6], act[5:2], act[1],
                     exp[10], exp[9:7], exp[6], exp[5:2], exp[1]);
        end
    endtask

    function automatic logic [10:0] dut_out();
        return {caught, eaten, wall_hit, wall_edge, grace, 1'b0};
    endfunction

    function automatic logic [10:0] model_out();
        return {m_caught, m_eaten, m_wall, m_edge, m_grace, 1'b0};
    endfunction

    // Drive at negedge, let the DUT sample at posedge, return at next negedge.
    task automatic drive(input logic s, sh, p, w, t, r1, r2, input logic [3:0] e);
        sof = s; shift = sh; pac = p; wall = w; trk = t; rs = r1; rd = r2; ecode = e;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sof = 0; shift = 0; pac = 0; wall = 0; trk = 0; rs = 0; rd = 0; ecode = 0;
    endtask

    // Asynchronous reset asserted away from the clock edge.
    task automatic pulse_reset(input string name);
        resetN = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        check(name, dut_out(), 11'd0);
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    function automatic vec_t mk(input logic s, sh, p, w, t, r1, r2, input logic [3:0] e,
                                input logic ec_, input logic [2:0] ee, input logic ew,
                                input logic [3:0] ed, input logic eg);
        vec_t v;
        v.sof = s; v.shift = sh; v.pac = p; v.wall = w; v.trk = t; v.rs = r1; v.rd = r2;
        v.ec = e; v.e_caught = ec_; v.e_eaten = ee; v.e_wall = ew; v.e_edge = ed; v.e_grace = eg;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [3:0] eC, e5;
        eC = WALL_EN ? 4'hC : 4'h0;
        e5 = WALL_EN ? 4'h5 : 4'h0;
        //            sof sh pac wl trk rs rd ec    caught eaten  wall     edge grace
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 1, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'h0, 1, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 4'h0, 0, 3'b110, 0,       4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 4'h0, 0, 3'b000, 0,       4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 4'h0, 0, 3'b000, 0,       4'h0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 4'h0, 0, 3'b110, 0,       4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 4'h0, 0, 3'b001, 0,       4'h0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 4'h0, 0, 3'b001, 0,       4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 4'h0, 0, 3'b000, 0,       4'h0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 4'h0, 0, 3'b010, 0,       4'h0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'hC, 0, 3'b000, WALL_EN, eC,   0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'h3, 0, 3'b000, 0,       eC,   0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 0,       eC,   0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'h5, 0, 3'b000, WALL_EN, e5,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 0,       e5,   0));
    end

    initial begin
        model_reset();
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", dut_out(), 11'd0);
        resetN = 1'b1;

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sof, tbl[i].shift, tbl[i].pac, tbl[i].wall, tbl[i].trk,
                  tbl[i].rs, tbl[i].rd, tbl[i].ec);
            check($sformatf("vec%0d", i), dut_out(),
                  {tbl[i].e_caught, tbl[i].e_eaten, tbl[i].e_wall, tbl[i].e_edge, tbl[i].e_grace, 1'b0});
        end

        // Reset mid-grace with two frames left, then confirm ARMED and clear flags.
        drive(1, 0, 0, 0, 0, 0, 0, 4'h0);
        drive(0, 0, 1, 0, 0, 0, 1, 4'h0);
        check("grace_catch", {caught, grace}, {11'b0, 2'b11} >> 0 & 11'b11);
        drive(1, 0, 0, 0, 0, 0, 0, 4'h0);
        check("grace_cnt2", {10'd0, grace}, 11'd1);
        pulse_reset("reset_mid_grace");
        drive(0, 0, 0, 0, 0, 0, 0, 4'h0);
        check("post_reset_idle", dut_out(), 11'd0);
        drive(0, 0, 1, 0, 0, 1, 0, 4'h0);
        check("post_reset_catch", dut_out(), {1'b1, 3'b000, 1'b0, 4'h0, 1'b1, 1'b0});

        // Randomized traffic against the frame-level model.
        for (int c = 0; c < 4000; c++) begin
            logic s, sh, p, w, t, r1, r2;
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset("rand_reset");
                continue;
            end
            s  = ($urandom_range(0, 9) == 0);
            sh = (($urandom_range(0, 19) == 0) ? ~shift : shift);
            p  = ($urandom_range(0, 2) == 0);
            w  = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 3) == 0);
            r1 = ($urandom_range(0, 3) == 0);
            r2 = ($urandom_range(0, 3) == 0);
            drive(s, sh, p, w, t, r1, r2, 4'($urandom));
            check("random", dut_out(), model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
